// File: rtl/tea_pkg.sv
// Shared TEA constants, FSM state encoding and key/round helpers for the TEA encryptor.
// The optional two-cycles-per-clock datapath is selected with TEA_ENC_UNROLL2_EN.
package tea_pkg;

  localparam logic [31:0] TEA_DELTA     = 32'h9E3779B9;
  localparam int          TEA_ROUNDS    = 32;
  localparam logic [31:0] TEA_SUM_FINAL = 32'hC6EF3720;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } tea_state_e;

  // k0 is the most significant word of the 128-bit key.
  localparam logic [1:0] KEY_K0 = 2'd0;
  localparam logic [1:0] KEY_K1 = 2'd1;
  localparam logic [1:0] KEY_K2 = 2'd2;
  localparam logic [1:0] KEY_K3 = 2'd3;

  function automatic logic [31:0] tea_key_word(input logic [127:0] k, input logic [1:0] idx);
    logic [31:0] w;
    case (idx)
      KEY_K0:  w = k[127:96];
      KEY_K1:  w = k[95:64];
      KEY_K2:  w = k[63:32];
      default: w = k[31:0];
    endcase
    return w;
  endfunction

  // Half-round mixing term; v is the half being fed in, s the already advanced sum.
  function automatic logic [31:0] tea_mix(input logic [31:0] v, input logic [31:0] s,
                                          input logic [31:0] ka, input logic [31:0] kb);
    return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
  endfunction

endpackage

// File: rtl/tea_enc_round.sv
// One combinational TEA Feistel cycle (both half-rounds); sum_n is the sum after adding delta.
module tea_enc_round
  import tea_pkg::*;
(
  input  logic [31:0] v0,
  input  logic [31:0] v1,
  input  logic [31:0] sum_n,
  input  logic [31:0] k0,
  input  logic [31:0] k1,
  input  logic [31:0] k2,
  input  logic [31:0] k3,
  output logic [31:0] v0_n,
  output logic [31:0] v1_n
);

  // The second half-round consumes the freshly updated v0.
  assign v0_n = v0 + tea_mix(v1, sum_n, k0, k1);
  assign v1_n = v1 + tea_mix(v0_n, sum_n, k2, k3);

endmodule

// File: rtl/tea_encryptor.sv
// Iterative handshaked TEA block encryptor, one Feistel cycle per clock.
// Defining TEA_ENC_UNROLL2_EN chains two cycles per clock, halving latency.
module tea_encryptor
  import tea_pkg::*;
#(
  parameter int ROUNDS = TEA_ROUNDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key,
  input  logic [63:0]  plain,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [63:0]  cipher,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] RUN  = ST_RUN;
  localparam logic [1:0] DONE = ST_DONE;

`ifdef TEA_ENC_UNROLL2_EN
  localparam int STEPS = ROUNDS / 2;
`else
  localparam int STEPS = ROUNDS;
`endif
  localparam int              CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      sum_q;
  logic [31:0]      v0_q;
  logic [31:0]      v1_q;
  logic [127:0]     key_q;

  logic [31:0] k0, k1, k2, k3;
  logic [31:0] sum_a;
  logic [31:0] sum_n;
  logic [31:0] v0_n;
  logic [31:0] v1_n;

  assign k0 = tea_key_word(key_q, KEY_K0);
  assign k1 = tea_key_word(key_q, KEY_K1);
  assign k2 = tea_key_word(key_q, KEY_K2);
  assign k3 = tea_key_word(key_q, KEY_K3);

  assign sum_a = sum_q + TEA_DELTA;

`ifdef TEA_ENC_UNROLL2_EN
  logic [31:0] v0_a;
  logic [31:0] v1_a;
  logic [31:0] sum_b;

  assign sum_b = sum_a + TEA_DELTA;

  tea_enc_round u_round0 (
    .v0    (v0_q),
    .v1    (v1_q),
    .sum_n (sum_a),
    .k0    (k0),
    .k1    (k1),
    .k2    (k2),
    .k3    (k3),
    .v0_n  (v0_a),
    .v1_n  (v1_a)
  );

  tea_enc_round u_round1 (
    .v0    (v0_a),
    .v1    (v1_a),
    .sum_n (sum_b),
    .k0    (k0),
    .k1    (k1),
    .k2    (k2),
    .k3    (k3),
    .v0_n  (v0_n),
    .v1_n  (v1_n)
  );

  assign sum_n = sum_b;
`else
  tea_enc_round u_round0 (
    .v0    (v0_q),
    .v1    (v1_q),
    .sum_n (sum_a),
    .k0    (k0),
    .k1    (k1),
    .k2    (k2),
    .k3    (k3),
    .v0_n  (v0_n),
    .v1_n  (v1_n)
  );

  assign sum_n = sum_a;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign cipher    = {v0_q, v1_q};

  // Data registers are reset too so the block presents all-zero state after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      sum_q <= '0;
      v0_q  <= '0;
      v1_q  <= '0;
      key_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            key_q <= key;
            v0_q  <= plain[63:32];
            v1_q  <= plain[31:0];
            sum_q <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_q <= sum_n;
          v0_q  <= v0_n;
          v1_q  <= v1_n;
          if (cnt == LAST) begin
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tea_encryptor.sv
// Directed bench for tea_encryptor against a reference TEA encrypt/decrypt model.
module tb_tea_encryptor;

`ifdef TEA_ENC_UNROLL2_EN
  localparam int EXP_LAT = 16;
  localparam int EXP_INT = 18;
`else
  localparam int EXP_LAT = 32;
  localparam int EXP_INT = 34;
`endif
  localparam logic [63:0]  ZERO_CT = 64'h41EA3A0A_94BAA940;
  localparam logic [127:0] KEY_A   = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] key;
  logic [63:0]  plain;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  cipher;
  logic         out_valid;
  logic         out_ready;

  int n_cmp = 0;
  int n_err = 0;

  tea_encryptor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key       (key),
    .plain     (plain),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cipher    (cipher),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_enc(input logic [127:0] k, input logic [63:0] p);
    logic [31:0] v0, v1, s;
    v0 = p[63:32];
    v1 = p[31:0];
    s  = 32'h0;
    for (int i = 0; i < 32; i++) begin
      s  = s + 32'h9E3779B9;
      v0 = v0 + (((v1 << 4) + k[127:96]) ^ (v1 + s) ^ ((v1 >> 5) + k[95:64]));
      v1 = v1 + (((v0 << 4) + k[63:32]) ^ (v0 + s) ^ ((v0 >> 5) + k[31:0]));
    end
    return {v0, v1};
  endfunction

  function automatic logic [63:0] ref_dec(input logic [127:0] k, input logic [63:0] c);
    logic [31:0] v0, v1, s;
    v0 = c[63:32];
    v1 = c[31:0];
    s  = 32'hC6EF3720;
    for (int i = 0; i < 32; i++) begin
      v1 = v1 - (((v0 << 4) + k[63:32]) ^ (v0 + s) ^ ((v0 >> 5) + k[31:0]));
      v0 = v0 - (((v1 << 4) + k[127:96]) ^ (v1 + s) ^ ((v1 >> 5) + k[95:64]));
      s  = s - 32'h9E3779B9;
    end
    return {v0, v1};
  endfunction

  // Accepts one block, waits for out_valid, and completes the handshake if out_ready is high.
  task automatic run_block(input logic [127:0] k, input logic [63:0] p,
                           output logic [63:0] c, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin
      step();
      w++;
    end
    chk("wait_in_ready", 64'(in_ready), 64'd1);
    key      = k;
    plain    = p;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    c = cipher;
    if (out_ready) step();
  endtask

  initial begin
    logic [63:0]  c, c0, p;
    logic [127:0] k;
    int           lat, na, no, cyc, any_ov;
    int           acc_t[2];
    logic [63:0]  outs[2];
    logic         pre_acc, pre_ov;
    logic [63:0]  pre_c;

    // Reset with in_valid high: nothing may be accepted.
    rst_n     = 1'b0;
    key       = '0;
    plain     = '0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    repeat (3) step();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_cipher", cipher, 64'd0);

    rst_n = 1'b1;
    step();
    chk("first_accept", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    chk("zero_latency", 64'(lat), 64'(EXP_LAT));
    chk("zero_cipher", cipher, ZERO_CT);
    step();
    chk("zero_back_idle", 64'(in_ready), 64'd1);

    // Round-trip through the decryptor model with a fixed key.
    for (int i = 0; i < 200; i++) begin
      p = {$urandom, $urandom};
      run_block(KEY_A, p, c, lat);
      chk("rand_enc", c, ref_enc(KEY_A, p));
      chk("rand_roundtrip", ref_dec(KEY_A, c), p);
    end

    // Output stall: cipher held, new inputs ignored.
    out_ready = 1'b0;
    p = 64'h01234567_89ABCDEF;
    run_block(KEY_A, p, c0, lat);
    chk("stall_cipher0", c0, ref_enc(KEY_A, p));
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      key      = {$urandom, $urandom, $urandom, $urandom};
      plain    = {$urandom, $urandom};
      step();
      chk("stall_cipher", cipher, c0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("stall_release", 64'(in_ready), 64'd1);
    chk("stall_release_ov", 64'(out_valid), 64'd0);

    // Back-to-back with in_valid held high.
    in_valid = 1'b1;
    key      = KEY_A;
    plain    = 64'hDEADBEEF_00C0FFEE;
    na = 0;
    no = 0;
    cyc = 0;
    for (int i = 0; i < 100 && no < 2; i++) begin
      pre_acc = in_ready & in_valid;
      pre_ov  = out_valid;
      pre_c   = cipher;
      step();
      cyc++;
      if (pre_acc && na < 2) begin
        acc_t[na] = cyc;
        na++;
        if (na == 1) plain = 64'h13579BDF_2468ACE0;
        else in_valid = 1'b0;
      end
      if (pre_ov && no < 2) begin
        outs[no] = pre_c;
        no++;
      end
    end
    in_valid = 1'b0;
    chk("b2b_accepts", 64'(na), 64'd2);
    chk("b2b_outputs", 64'(no), 64'd2);
    if (na == 2) chk("b2b_interval", 64'(acc_t[1] - acc_t[0]), 64'(EXP_INT));
    if (no == 2) begin
      chk("b2b_ct0", outs[0], ref_enc(KEY_A, 64'hDEADBEEF_00C0FFEE));
      chk("b2b_ct1", outs[1], ref_enc(KEY_A, 64'h13579BDF_2468ACE0));
    end

    // Inputs scrambled every cycle during RUN.
    k = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    p = 64'hCAFEBABE_FEEDFACE;
    key      = k;
    plain    = p;
    in_valid = 1'b1;
    step();
    lat = 0;
    while (!out_valid && lat < 100) begin
      key      = {$urandom, $urandom, $urandom, $urandom};
      plain    = {$urandom, $urandom};
      in_valid = 1'($urandom_range(0, 1));
      step();
      lat++;
    end
    in_valid = 1'b0;
    chk("scramble_latency", 64'(lat), 64'(EXP_LAT));
    chk("scramble_cipher", cipher, ref_enc(k, p));
    step();

    // Reset in the middle of RUN.
    key      = KEY_A;
    plain    = 64'hFFFFFFFF_00000001;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (15) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_cipher", cipher, 64'd0);
    any_ov = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) any_ov = 1;
    end
    chk("midrst_no_pulse", 64'(any_ov), 64'd0);
    run_block('0, '0, c, lat);
    chk("midrst_zero_ct", c, ZERO_CT);
    chk("midrst_zero_lat", 64'(lat), 64'(EXP_LAT));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tea_encryptor.md
# tea_encryptor

Iterative, handshaked TEA block encryptor; the transmit-side counterpart of the team's combinational TEA decryptor. It accepts one 64-bit plaintext block plus a 128-bit key and computes one Feistel cycle (both half-rounds) per clock. It presents the 64-bit ciphertext on a valid/ready output port. Its output decrypts bit-exactly in the existing decryptor with the same key.

## Interface
- `ROUNDS`, default 32: number of Feistel cycles. Must be 32 for interoperability with the decryptor. Legal range 2..32, even.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `key`  in  128  key words: k0=`key[127:96]`, k1=`key[95:64]`, k2=`key[63:32]`, k3=`key[31:0]`. Sampled only at input handshake.
- `plain`  in  64  plaintext: v0=`plain[63:32]`, v1=`plain[31:0]`.
- `in_valid`  in  1  plaintext/key valid.
- `in_ready`  out  1  block can accept a new input.
- `cipher`  out  64  ciphertext `{v0,v1}`.
- `out_valid`  out  1  ciphertext valid.
- `out_ready`  in  1  consumer accepts ciphertext.

## Operation
- States:
  - IDLE: `in_ready`=1. On `in_valid`, latch the key and split the plaintext into v0/v1. Set sum=0 and round counter=0, then go to RUN.
  - RUN: one cycle per edge. When the counter reaches ROUNDS-1, go to DONE; otherwise increment the counter.
  - DONE: `out_valid`=1. On `out_ready`, go to IDLE.
- One cycle, all arithmetic mod 2^32, `<<`/`>>` logical:
  - sum' = sum + 0x9E3779B9
  - v0' = v0 + (((v1<<4)+k0) ^ (v1+sum') ^ ((v1>>5)+k1))
  - v1' = v1 + (((v0'<<4)+k2) ^ (v0'+sum') ^ ((v0'>>5)+k3))
  - v1' uses the updated v0'.
- After 32 cycles sum = 0xC6EF3720, which matches the decryptor's starting sum.
- `cipher` is driven from the v0/v1 registers. It is held stable while `out_valid`=1 and `out_ready`=0.
- Changes on `key`/`plain`/`in_valid` outside IDLE are ignored. There is no abort input.
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `cipher`=0, sum=0, counter=0, key register=0.

## Timing
- Input handshake: rising edge with `in_valid`&`in_ready`. This is edge T0.
- Rounds execute on edges T1..T_ROUNDS.
- `out_valid` rises after edge T_ROUNDS. Latency is 32 cycles for default ROUNDS.
- `in_ready` is low from after T0 until after the output handshake edge.
- Minimum issue interval: ROUNDS+2 cycles (34 by default). This holds with `out_ready` tied high: 1 IDLE, 32 RUN, 1 DONE.
- `rst_n` low on any edge, including mid-RUN or in DONE, forces the reset values on that edge. The partial result is discarded and `out_valid` does not pulse.
- `out_ready` high while `out_valid`=0 has no effect.
- `in_valid` high during reset is not accepted. The first acceptance is on the first edge with `rst_n`=1.

## Configuration
- `TEA_ENC_UNROLL2_EN`:
  - Defined: two Feistel cycles are chained combinationally per clock. sum advances by 2×delta per edge, and RUN lasts ROUNDS/2 edges. Latency is 16 and the issue interval is 18 (default ROUNDS).
  - Undefined: one cycle per clock, as above.
  - Ciphertext is identical either way.

## Structure
- Package `tea_pkg` holds:
  - `TEA_DELTA` = 32'h9E3779B9 and `TEA_ROUNDS` = 32
  - `TEA_SUM_FINAL` = 32'hC6EF3720
  - state enum (IDLE, RUN, DONE)
  - key-word index constants.
- Sub-module `tea_enc_round` is combinational: one Feistel cycle with ports v0, v1, sum', k0..k3 → v0', v1'. It is instantiated once, or twice in series under `TEA_ENC_UNROLL2_EN`.

## Test plan
- Key=0, plain=0, `out_ready`=1 → `cipher`=0x41EA3A0A_94BAA940. `out_valid` rises exactly 32 cycles after acceptance (16 with `TEA_ENC_UNROLL2_EN`).
- Key=0x00112233_44556677_8899AABB_CCDDEEFF, 200 random plaintexts → feeding each `cipher` back through the TEA decryptor model with the same key returns the original plaintext.
- Hold `out_ready`=0 for 10 cycles in DONE → `cipher` is stable, `out_valid` stays 1, `in_ready` stays 0. A new `in_valid` plus a new key during this window is ignored, and the ciphertext is unchanged.
- Back-to-back: `in_valid` held high, `out_ready`=1, two distinct blocks → acceptances are exactly 34 cycles apart and both ciphertexts are correct.
- Change `key` and `plain` on every cycle during RUN → the result equals the encryption of the values latched at acceptance.
- Assert `rst_n`=0 for one cycle at round 15 → the next edge shows IDLE, `out_valid`=0, `cipher`=0. A subsequent encryption of plain=0/key=0 returns 0x41EA3A0A_94BAA940.
